huffman_param: RTL



---
 rtl/huffman_pkg.sv | 41 ++++
 rtl/huffman_min2.sv | 63 ++++++
 rtl/huffman_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and helpers for the parametrised Huffman encoder.
//   state_t        - controller states IDLE/COUNT/CNT_OUT/BUILD/DONE
//   node_t         - merge-tree node {weight, member mask, active}; the fields
//                    are sized for the largest supported build (16 symbols)
//   wgt_w()        - node weight width that can hold any sum of counts
//   lowest_member()- index of the lowest set bit of a member mask (tie-break key)
package huffman_pkg;

  localparam int MAX_SYM   = 16;
  localparam int MAX_WGT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_CNT_OUT = 3'd2,
    ST_BUILD   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [MAX_WGT_W-1:0] weight;
    logic [MAX_SYM-1:0]   members;
    logic                 active;
  } node_t;

  // Total of NUM_SYM counts of CNT_W bits never exceeds CNT_W+clog2(NUM_SYM) bits.
  function automatic int wgt_w(input int cnt_w, input int num_sym);
    return cnt_w + $clog2(num_sym);
  endfunction

  function automatic logic [3:0] lowest_member(input logic [MAX_SYM-1:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    // Scan downwards so the last hit is the lowest set bit.
    for (int i = MAX_SYM - 1; i >= 0; i--) begin
      idx = mask[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/huffman_min2.sv
// huffman_min2: combinational two-minimum finder over the node list.
//   nodes  in   node list (NUM_SYM entries)
//   min1   out  index of the lightest active node
//   min2   out  index of the next lightest active node
//   valid  out  1 when at least two nodes are active (a merge is possible)
// Ordering: lower weight first; on equal weight the node whose lowest member
// index is larger comes first.
module huffman_min2
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = 6
) (
  input  node_t                      nodes [NUM_SYM],
  output logic [$clog2(NUM_SYM)-1:0] min1,
  output logic [$clog2(NUM_SYM)-1:0] min2,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_SYM);

  logic f1_s;
  logic f2_s;

  // True when node a should be picked ahead of node b.
  function automatic logic better(input node_t a, input node_t b);
    logic res;
    if (a.weight < b.weight) begin
      res = 1'b1;
    end else if (a.weight == b.weight) begin
      res = (lowest_member(a.members) > lowest_member(b.members));
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  // Two sequential scans: best node, then best node excluding the first.
  always_comb begin
    min1 = '0;
    min2 = '0;
    f1_s = 1'b0;
    f2_s = 1'b0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (nodes[i].active && (!f1_s || better(nodes[i], nodes[min1]))) begin
        min1 = IDX_W'(i);
        f1_s = 1'b1;
      end else begin
        // current best stands
      end
    end
    for (int i = 0; i < NUM_SYM; i++) begin
      if (nodes[i].active && (i != int'(min1)) &&
          (!f2_s || better(nodes[i], nodes[min2]))) begin
        min2 = IDX_W'(i);
        f2_s = 1'b1;
      end else begin
        // current runner-up stands
      end
    end
    valid = f1_s & f2_s;
  end

endmodule

// File: rtl/huffman_param.sv
// huffman_param: per-frame symbol histogram followed by Huffman code build.
//   clk, reset  clock and asynchronous active-high reset
//   gray_valid  sample strobe; a frame is a contiguous run of valid cycles
//   gray_data   symbol value; only 1..NUM_SYM are counted
//   busy        high whenever the controller is not idle
//   CNT_valid   one-cycle pulse, CNT final (slice k-1 = count of symbol k)
//   CNT         per-symbol counts
//   code_valid  one-cycle pulse, HC and M final
//   HC, M       per-symbol code (LSB-aligned, root bit at the top) and mask
// Build option: HUFF_SAT_EN makes counts saturate at 2^CNT_W-1; without it
// counts wrap and a count that wraps to 0 marks the symbol inactive.
module huffman_param
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int CODE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      gray_valid,
  input  logic [DATA_W-1:0]         gray_data,
  output logic                      busy,
  output logic                      CNT_valid,
  output logic [NUM_SYM*CNT_W-1:0]  CNT,
  output logic                      code_valid,
  output logic [NUM_SYM*CODE_W-1:0] HC,
  output logic [NUM_SYM*CODE_W-1:0] M
);

  localparam int WGT_W = wgt_w(CNT_W, NUM_SYM);
  localparam int IDX_W = $clog2(NUM_SYM);

  state_t              state_r;
  logic                busy_r;
  logic                cnt_valid_r;
  logic                code_valid_r;
  logic [CNT_W-1:0]    cnt_r  [NUM_SYM];
  logic [CODE_W-1:0]   hc_r   [NUM_SYM];
  logic [CODE_W-1:0]   m_r    [NUM_SYM];
  node_t               node_r [NUM_SYM];
  logic [IDX_W-1:0]    min1_s;
  logic [IDX_W-1:0]    min2_s;
  logic                pair_valid_s;
  logic [NUM_SYM-1:0]  hit_s;
  logic [WGT_W-1:0]    sum_s;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef HUFF_SAT_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  huffman_min2 #(.NUM_SYM(NUM_SYM)) u_min2 (
    .nodes (node_r),
    .min1  (min1_s),
    .min2  (min2_s),
    .valid (pair_valid_s)
  );

  assign sum_s = WGT_W'(node_r[min1_s].weight + node_r[min2_s].weight);

  // One-hot decode of the incoming sample against symbols 1..NUM_SYM.
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      hit_s[k] = gray_valid && (32'(gray_data) == 32'(k + 1));
    end
  end

  // Controller, histogram and code-build state.
  // CNT_valid is registered out of the CNT_OUT state (visible on the first
  // BUILD cycle) and code_valid on the BUILD->DONE edge (visible in DONE), so
  // code_valid trails CNT_valid by the number of active symbols, minimum 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      cnt_valid_r  <= 1'b0;
      code_valid_r <= 1'b0;
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_r[k]  <= '0;
        hc_r[k]   <= '0;
        m_r[k]    <= '0;
        node_r[k] <= '0;
      end
    end else begin
      cnt_valid_r  <= 1'b0;
      code_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gray_valid) begin
            for (int k = 0; k < NUM_SYM; k++) begin
              cnt_r[k] <= hit_s[k] ? CNT_W'(1) : CNT_W'(0);
              hc_r[k]  <= '0;
              m_r[k]   <= '0;
            end
            state_r <= ST_COUNT;
            busy_r  <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (gray_valid) begin
            for (int k = 0; k < NUM_SYM; k++) begin
              if (hit_s[k]) begin
                cnt_r[k] <= bump(cnt_r[k]);
              end
            end
          end else begin
            state_r <= ST_CNT_OUT;
          end
        end
        ST_CNT_OUT: begin
          cnt_valid_r <= 1'b1;
          for (int k = 0; k < NUM_SYM; k++) begin
            node_r[k].weight  <= MAX_WGT_W'(cnt_r[k]);
            node_r[k].members <= MAX_SYM'(1) << k;
            node_r[k].active  <= (cnt_r[k] != CNT_W'(0));
          end
          state_r <= ST_BUILD;
        end
        ST_BUILD: begin
          if (pair_valid_s) begin
            // m+1 is the one-hot bit at the member's current length.
            for (int k = 0; k < NUM_SYM; k++) begin
              if (node_r[min1_s].members[k]) begin
                hc_r[k] <= hc_r[k] | (m_r[k] + CODE_W'(1));
                m_r[k]  <= (m_r[k] << 1) | CODE_W'(1);
              end else if (node_r[min2_s].members[k]) begin
                m_r[k]  <= (m_r[k] << 1) | CODE_W'(1);
              end
            end
            node_r[min2_s].weight  <= MAX_WGT_W'(sum_s);
            node_r[min2_s].members <= node_r[min2_s].members | node_r[min1_s].members;
            node_r[min1_s].active  <= 1'b0;
          end else begin
            // Slot k always keeps symbol k as a member, so a zero mask on an
            // active slot only happens when a single symbol was present.
            for (int k = 0; k < NUM_SYM; k++) begin
              if (node_r[k].active && (m_r[k] == CODE_W'(0))) begin
                m_r[k] <= CODE_W'(1);
              end
            end
            code_valid_r <= 1'b1;
            state_r      <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign CNT_valid  = cnt_valid_r;
  assign code_valid = code_valid_r;

  for (genvar g = 0; g < NUM_SYM; g++) begin : g_flat
    assign CNT[g*CNT_W +: CNT_W]  = cnt_r[g];
    assign HC[g*CODE_W +: CODE_W] = hc_r[g];
    assign M[g*CODE_W +: CODE_W]  = m_r[g];
  end

endmodule
